// File: rtl/processor_input_poller.sv
// Polls a 4-bit input PIO over Avalon-MM, debounces the samples, latches edge
// events and exposes stable/edge/mask/period registers through a small slave.
module processor_input_poller #(
    parameter int DATA_WIDTH     = 4,
    parameter int PERIOD_WIDTH   = 16,
    parameter int DEFAULT_PERIOD = 1000,
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic [1:0]              pio_address,
    output logic                    pio_read,
    input  logic [31:0]             pio_readdata,
    input  logic [1:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic                    irq
);
    localparam int CW = 4;

    typedef enum logic [1:0] {S_WAIT, S_ISSUE, S_CAPTURE, S_UPDATE} state_t;

    state_t                  state_reg;
    logic [PERIOD_WIDTH-1:0] counter_reg;
    logic [PERIOD_WIDTH-1:0] period_reg;
    logic [DATA_WIDTH-1:0]   sample_reg;
    logic [DATA_WIDTH-1:0]   candidate_reg, candidate_next;
    logic [CW-1:0]           count_reg, count_next;
    logic [DATA_WIDTH-1:0]   stable_reg, stable_next;
    logic [DATA_WIDTH-1:0]   edge_reg, edge_next;
    logic [DATA_WIDTH-1:0]   mask_reg, mask_next;
    logic [31:0]             read_mux;
    logic                    write_en;
    logic                    unused_bits;

    assign pio_address = 2'b00;
    assign write_en    = chipselect & ~write_n;
    assign unused_bits = ^{pio_readdata, writedata};

    // Debounce step and slave writes; an edge set in UPDATE overrides a same-cycle W1C.
    always_comb begin
        candidate_next = candidate_reg;
        count_next     = count_reg;
        stable_next    = stable_reg;
        edge_next      = edge_reg;
        mask_next      = mask_reg;
        if (write_en && address == 2'd1)
            edge_next = edge_reg & ~writedata[DATA_WIDTH-1:0];
        if (write_en && address == 2'd2)
            mask_next = writedata[DATA_WIDTH-1:0];
        if (state_reg == S_UPDATE) begin
            if (sample_reg == candidate_reg) begin
                if (count_reg < CW'(DEBOUNCE_COUNT))
                    count_next = count_reg + CW'(1);
            end else begin
                candidate_next = sample_reg;
                count_next     = CW'(1);
            end
            if (count_next == CW'(DEBOUNCE_COUNT) && candidate_next != stable_reg) begin
                stable_next = candidate_next;
                edge_next   = edge_next | (stable_reg ^ candidate_next);
            end
        end
    end

    always_comb begin
        read_mux = '0;
        case (address)
            2'd0: read_mux[DATA_WIDTH-1:0]   = stable_reg;
            2'd1: read_mux[DATA_WIDTH-1:0]   = edge_reg;
            2'd2: read_mux[DATA_WIDTH-1:0]   = mask_reg;
            default: read_mux[PERIOD_WIDTH-1:0] = period_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_WAIT;
            counter_reg   <= PERIOD_WIDTH'(DEFAULT_PERIOD);
            period_reg    <= PERIOD_WIDTH'(DEFAULT_PERIOD);
            sample_reg    <= '0;
            candidate_reg <= '0;
            count_reg     <= '0;
            stable_reg    <= '0;
            edge_reg      <= '0;
            mask_reg      <= '0;
            pio_read      <= 1'b0;
            readdata      <= '0;
            irq           <= 1'b0;
        end else begin
            case (state_reg)
                S_WAIT: begin
                    if (counter_reg <= PERIOD_WIDTH'(1)) begin
                        state_reg <= S_ISSUE;
                        pio_read  <= 1'b1;
                    end else begin
                        counter_reg <= counter_reg - PERIOD_WIDTH'(1);
                    end
                end
                S_ISSUE: begin
                    pio_read  <= 1'b0;
                    state_reg <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    sample_reg <= pio_readdata[DATA_WIDTH-1:0];
                    state_reg  <= S_UPDATE;
                end
                default: begin
                    // Reload from the period register so a write mid-countdown only affects the next interval.
                    counter_reg <= period_reg;
                    state_reg   <= S_WAIT;
                end
            endcase

            if (write_en && address == 2'd3)
                period_reg <= writedata[PERIOD_WIDTH-1:0];

            candidate_reg <= candidate_next;
            count_reg     <= count_next;
            stable_reg    <= stable_next;
            edge_reg      <= edge_next;
            mask_reg      <= mask_next;
            irq           <= |(edge_next & mask_next);
            readdata      <= chipselect ? read_mux : 32'd0;
        end
    end
endmodule

// File: tb/tb_processor_input_poller.sv
// Directed and randomized checks of processor_input_poller against a
// run-length debounce model fed from a PIO-read monitor.
module tb_processor_input_poller;
    localparam int DW = 4;
    localparam int PW = 16;
    localparam int DP = 1000;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  pio_address;
    logic        pio_read;
    logic [31:0] pio_readdata = '0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    logic [3:0]  in_port = 4'h0;
    logic [3:0]  mon_q[$];
    logic [3:0]  hist[$];
    logic [3:0]  m_stable, m_edge, m_mask;
    int          checks = 0;
    int          errors = 0;

    processor_input_poller #(
        .DATA_WIDTH(DW), .PERIOD_WIDTH(PW), .DEFAULT_PERIOD(DP), .DEBOUNCE_COUNT(DC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pio_address(pio_address), .pio_read(pio_read),
        .pio_readdata(pio_readdata), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // PIO slave: registered readdata with garbage in the upper bits.
    logic [31:0] rnd;
    always @(posedge clk) begin
        if (pio_read) begin
            rnd = $urandom;
            pio_readdata <= {rnd[31:4], in_port};
        end
    end

    // Every PIO read the poller makes, in order.
    always @(posedge clk) begin
        if (reset_n && pio_read) mon_q.push_back(in_port);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_stable = '0; m_edge = '0; m_mask = '0;
        hist.delete();
    endtask

    // A value is accepted once it has been seen DC polls in a row and differs from stable.
    task automatic model_sample(input logic [3:0] s);
        int run;
        hist.push_back(s);
        if (hist.size() > DC) void'(hist.pop_front());
        run = 0;
        foreach (hist[i]) if (hist[i] == s) run++; else run = 0;
        if (run >= DC && s != m_stable) begin
            m_edge   = m_edge | (s ^ m_stable);
            m_stable = s;
        end
    endtask

    task automatic wait_read(input int limit, output int cnt, output bit found);
        cnt = 0; found = 1'b0;
        while (cnt < limit) begin
            @(negedge clk);
            cnt++;
            if (pio_read) begin found = 1'b1; break; end
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        if (a == 2'd1) m_edge = m_edge & ~d[3:0];
        if (a == 2'd2) m_mask = d[3:0];
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    // Wait for a poll, let it finish, update the model and compare.
    task automatic poll(input bit do_reads, input bit collide, input logic [31:0] cwd);
        int cnt; bit found; logic [31:0] d;
        wait_read(2000, cnt, found);
        chk("pio_read_seen", 32'(found), 32'd1);
        if (!found) return;
        chk("pio_address", 32'(pio_address), 32'd0);
        @(negedge clk);
        @(negedge clk);
        if (collide) begin
            chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = cwd;
        end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        while (mon_q.size() > 1) model_sample(mon_q.pop_front());
        if (collide) m_edge = m_edge & ~cwd[3:0];
        if (mon_q.size() > 0) model_sample(mon_q.pop_front());
        chk("irq", 32'(irq), 32'(|(m_edge & m_mask)));
        if (do_reads) begin
            rd(2'd0, d); chk("stable", d, 32'(m_stable));
            rd(2'd1, d); chk("edge", d, 32'(m_edge));
        end
        $display("poll: in=%h stable=%h edge=%h irq=%0d", in_port, m_stable, m_edge, irq);
    endtask

    initial begin
        logic [31:0] d;
        int cnt; bit found;
        model_reset();
        in_port = 4'b0101;
        repeat (3) @(negedge clk);
        chk("rst_pio_read", 32'(pio_read), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_pio_address", 32'(pio_address), 32'd0);
        reset_n = 1'b1;
        rd(2'd3, d); chk("period_default", d, 32'(DP));
        rd(2'd0, d); chk("stable_reset", d, 32'd0);
        rd(2'd1, d); chk("edge_reset", d, 32'd0);
        rd(2'd2, d); chk("mask_reset", d, 32'd0);
        chk("readdata_idle", readdata, 32'd0);
        wr(2'd2, 32'hF);
        chk("irq_mask_only", 32'(irq), 32'd0);
        wr(2'd3, 32'd2);
        wr(2'd0, 32'hF);
        rd(2'd2, d); chk("mask_rw", d, 32'hF);
        rd(2'd0, d); chk("stable_ro", d, 32'd0);

        // Acceptance: 0101 held with period 2.
        for (int i = 0; i < 4; i++) begin
            poll(1'b0, 1'b0, 32'd0);
            chk("accept_irq", 32'(irq), (i == 3) ? 32'd1 : 32'd0);
        end
        wr(2'd3, 32'd6);
        poll(1'b1, 1'b0, 32'd0);
        rd(2'd0, d); chk("accept_stable", d, 32'h5);

        // W1C clear of bit 0.
        wr(2'd1, 32'h1);
        rd(2'd1, d); chk("w1c_edge", d, 32'h4);
        chk("w1c_irq", 32'(irq), 32'd1);

        // Collision: bit 2 clears while UPDATE sets it.
        in_port = 4'h1;
        for (int i = 0; i < 3; i++) poll(1'b1, 1'b0, 32'd0);
        poll(1'b1, 1'b1, 32'h4);
        rd(2'd1, d); chk("collide_edge", d, 32'h4);
        chk("collide_irq", 32'(irq), 32'd1);

        // Back to 0101, then glitch rejection.
        wr(2'd1, 32'hF);
        chk("clear_irq", 32'(irq), 32'd0);
        in_port = 4'h5;
        for (int i = 0; i < 4; i++) poll(1'b1, 1'b0, 32'd0);
        wr(2'd1, 32'hF);
        in_port = 4'h7;
        for (int i = 0; i < 2; i++) poll(1'b1, 1'b0, 32'd0);
        in_port = 4'h5;
        for (int i = 0; i < 4; i++) poll(1'b1, 1'b0, 32'd0);
        rd(2'd0, d); chk("glitch_stable", d, 32'h5);
        rd(2'd1, d); chk("glitch_edge", d, 32'h0);
        chk("glitch_irq", 32'(irq), 32'd0);

        // Randomized traffic.
        wr(2'd3, 32'($urandom_range(5, 9)));
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) in_port = 4'($urandom);
            poll(1'b1, 1'b0, 32'd0);
            if ($urandom_range(0, 3) == 0) begin
                wr(2'd2, 32'($urandom));
                chk("rand_mask_irq", 32'(irq), 32'(|(m_edge & m_mask)));
            end
            if ($urandom_range(0, 3) == 0) wr(2'd1, $urandom);
        end

        // Period 0 gives a 4-cycle loop.
        wr(2'd3, 32'd0);
        wait_read(100, cnt, found);
        wait_read(100, cnt, found); chk("period0_a", 32'(cnt), 32'd4);
        wait_read(100, cnt, found); chk("period0_b", 32'(cnt), 32'd4);
        wr(2'd3, 32'd3);
        wait_read(100, cnt, found);
        wait_read(100, cnt, found); chk("period3", 32'(cnt), 32'd6);
        repeat (3) @(negedge clk);
        wr(2'd3, 32'hFFFF);
        wait_read(100, cnt, found); chk("period_cur", 32'(cnt + 4), 32'd6);
        wait_read(70000, cnt, found); chk("period_ffff", 32'(cnt), 32'd65538);
        wr(2'd3, 32'd5);

        // Reset during CAPTURE with edge=3, mask=F.
        poll(1'b1, 1'b0, 32'd0);
        wr(2'd1, 32'hF);
        wr(2'd2, 32'hF);
        in_port = m_stable ^ 4'h3;
        for (int i = 0; i < 4; i++) poll(1'b1, 1'b0, 32'd0);
        rd(2'd1, d); chk("pre_reset_edge", d, 32'h3);
        wait_read(100, cnt, found);
        chk("pre_reset_read", 32'(found), 32'd1);
        chipselect = 1'b1; write_n = 1'b1; address = 2'd1;
        @(negedge clk);
        chk("capture_readdata", readdata, 32'h3);
        reset_n = 1'b0;
        #1;
        chk("midrst_irq", 32'(irq), 32'd0);
        chk("midrst_readdata", readdata, 32'd0);
        chk("midrst_pio_read", 32'(pio_read), 32'd0);
        chipselect = 1'b0;
        mon_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_read(2000, cnt, found); chk("first_read_after_reset", 32'(cnt), 32'(DP));
        rd(2'd1, d); chk("edge_after_reset", d, 32'd0);
        rd(2'd2, d); chk("mask_after_reset", d, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
